// File: rtl/urxd_pkg.sv
// Shared types and constants for the UART byte receiver.
// URXD_PARITY_EN moves the stop bit one slot later to make room for the parity bit.
package urxd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } rx_state_e;

    localparam logic [3:0] BIT_START     = 4'd0;
    localparam logic [3:0] BIT_FIRST_DAT = 4'd1;
    localparam logic [3:0] BIT_LAST_DAT  = 4'd8;
    localparam logic [3:0] BIT_PAR       = 4'd9;
`ifdef URXD_PARITY_EN
    localparam logic [3:0] BIT_STOP      = 4'd10;
`else
    localparam logic [3:0] BIT_STOP      = 4'd9;
`endif

    // Bit period in clocks; the receiver needs at least 8 clocks per bit.
    function automatic int calc_nt(input int f_clk, input int baud);
        return f_clk / baud;
    endfunction

    function automatic int calc_nt_half(input int f_clk, input int baud);
        return calc_nt(f_clk, baud) / 2;
    endfunction

endpackage

// File: rtl/urxd_byte_rx_if.sv
// Receive-side output bundle of urxd_byte_rx: data, status strobes and debug taps.
// The receiver drives the master modport; consumers attach to the slave modport.
interface urxd_byte_rx_if;
    logic [7:0] dat;
    logic       ok_rx;
    logic       err_stop;
    logic       err_par;
    logic       en_rx_byte;
    logic       ce_tact;
    logic [3:0] cb_bit;
    logic       T_start;
    logic       T_dat;
    logic       T_stop;

    modport master (
        output dat, ok_rx, err_stop, err_par, en_rx_byte,
        output ce_tact, cb_bit, T_start, T_dat, T_stop
    );

    modport slave (
        input dat, ok_rx, err_stop, err_par, en_rx_byte,
        input ce_tact, cb_bit, T_start, T_dat, T_stop
    );
endinterface

// File: rtl/urxd_sync_edge.sv
// Two-flop synchronizer for the serial line plus a falling-edge detector.
// All flops reset to 1 so an idle-high line never looks like a start edge.
module urxd_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_q    = r_s2;
    assign o_fall = r_s3 & ~r_s2;

endmodule

// File: rtl/urxd_byte_rx.sv
// UART byte receiver: 1 start, 8 data LSB first, 1 stop (8E1 when URXD_PARITY_EN is defined).
// Samples at mid-bit from the synchronized start edge; all strobes are registered, single cycle.
module urxd_byte_rx
    import urxd_pkg::*;
#(
    parameter int F_CLK = 50_000_000,
    parameter int BAUD  = 115200
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               URXD,
    urxd_byte_rx_if.master     o_rx
);

    localparam int NT      = calc_nt(F_CLK, BAUD);
    localparam int NT_HALF = calc_nt_half(F_CLK, BAUD);
    localparam int TMR_W   = $clog2(NT);

    // The edge is seen one cycle after the synchronizer output drops and the timer
    // starts one cycle after that, hence NT/2-2 to land the first sample at E+NT/2.
    localparam logic [TMR_W-1:0] TMR_FIRST = TMR_W'(NT_HALF - 2);
    localparam logic [TMR_W-1:0] TMR_BIT   = TMR_W'(NT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

    logic             w_rx;
    logic             w_fall;
    logic             w_expire;

    rx_state_e        r_state;
    rx_state_e        w_state_nxt;
    logic [TMR_W-1:0] r_tmr;
    logic [TMR_W-1:0] w_tmr_nxt;
    logic [3:0]       r_cb;
    logic [3:0]       w_cb_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic [7:0]       r_dat;
    logic [7:0]       w_dat_nxt;
    logic             r_ok;
    logic             w_ok_nxt;
    logic             r_err_stop;
    logic             w_err_stop_nxt;
    logic             r_ce;
    logic             w_ce_nxt;
`ifdef URXD_PARITY_EN
    logic             r_par_bad;
    logic             w_par_bad_nxt;
    logic             r_err_par;
    logic             w_err_par_nxt;
`endif

    urxd_sync_edge u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_d    (URXD),
        .o_q    (w_rx),
        .o_fall (w_fall)
    );

    assign w_expire = (r_tmr == '0);

    always_comb begin
        w_state_nxt    = r_state;
        w_tmr_nxt      = r_tmr;
        w_cb_nxt       = r_cb;
        w_shift_nxt    = r_shift;
        w_dat_nxt      = r_dat;
        w_ok_nxt       = 1'b0;
        w_err_stop_nxt = 1'b0;
        w_ce_nxt       = 1'b0;
`ifdef URXD_PARITY_EN
        w_par_bad_nxt  = r_par_bad;
        w_err_par_nxt  = 1'b0;
`endif

        if (r_state != ST_IDLE) begin
            if (w_expire) begin
                w_ce_nxt  = 1'b1;
                w_tmr_nxt = TMR_BIT;
            end else begin
                w_tmr_nxt = r_tmr - TMR_ONE;
            end
        end

        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = ST_START;
                    w_tmr_nxt   = TMR_FIRST;
                    w_cb_nxt    = BIT_START;
                end
            end
            ST_START: begin
                if (w_expire) begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (!w_rx) begin
                        w_state_nxt = ST_DATA;
                        w_cb_nxt    = BIT_FIRST_DAT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cb_nxt    = BIT_START;
                    end
                end
            end
            ST_DATA: begin
                if (w_expire) begin
                    w_shift_nxt = {w_rx, r_shift[7:1]};
                    w_cb_nxt    = r_cb + 4'd1;
                    if (r_cb == BIT_LAST_DAT) begin
`ifdef URXD_PARITY_EN
                        w_state_nxt = ST_PAR;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef URXD_PARITY_EN
            ST_PAR: begin
                if (w_expire) begin
                    w_par_bad_nxt = w_rx ^ (^r_shift);
                    w_state_nxt   = ST_STOP;
                    w_cb_nxt      = BIT_STOP;
                end
            end
`endif
            ST_STOP: begin
                // Leaving at mid-stop lets the next start edge follow without a gap.
                if (w_expire) begin
                    if (w_rx) begin
                        w_dat_nxt = r_shift;
                        w_ok_nxt  = 1'b1;
                    end else begin
                        w_err_stop_nxt = 1'b1;
                    end
`ifdef URXD_PARITY_EN
                    w_err_par_nxt = r_par_bad;
`endif
                    w_state_nxt = ST_IDLE;
                    w_cb_nxt    = BIT_START;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cb_nxt    = BIT_START;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_tmr      <= '0;
            r_cb       <= BIT_START;
            r_shift    <= 8'h00;
            r_dat      <= 8'h00;
            r_ok       <= 1'b0;
            r_err_stop <= 1'b0;
            r_ce       <= 1'b0;
`ifdef URXD_PARITY_EN
            r_par_bad  <= 1'b0;
            r_err_par  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_tmr      <= w_tmr_nxt;
            r_cb       <= w_cb_nxt;
            r_shift    <= w_shift_nxt;
            r_dat      <= w_dat_nxt;
            r_ok       <= w_ok_nxt;
            r_err_stop <= w_err_stop_nxt;
            r_ce       <= w_ce_nxt;
`ifdef URXD_PARITY_EN
            r_par_bad  <= w_par_bad_nxt;
            r_err_par  <= w_err_par_nxt;
`endif
        end
    end

    assign o_rx.dat        = r_dat;
    assign o_rx.ok_rx      = r_ok;
    assign o_rx.err_stop   = r_err_stop;
`ifdef URXD_PARITY_EN
    assign o_rx.err_par    = r_err_par;
`else
    assign o_rx.err_par    = 1'b0;
`endif
    assign o_rx.en_rx_byte = (r_state != ST_IDLE);
    assign o_rx.ce_tact    = r_ce;
    assign o_rx.cb_bit     = r_cb;
    assign o_rx.T_start    = (r_state == ST_START);
    assign o_rx.T_dat      = (r_state == ST_DATA);
    assign o_rx.T_stop     = (r_state == ST_STOP);

endmodule

// File: tb/tb_urxd_byte_rx.sv
// Bench for urxd_byte_rx at NT=20: serial frames with fractional bit periods, strobes
// logged with cycle stamps and compared against frame-level expectations.
module tb_urxd_byte_rx;

    localparam int NT = 20;
`ifdef URXD_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Strobe cycle relative to the cycle URXD is driven low (E = +2, stop sample at E+NT/2+(NBITS-1)*NT).
    localparam int STROBE_OFS = 2 + NT/2 + (NBITS-1)*NT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic URXD  = 1'b1;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;

    typedef struct {
        int         t;
        bit         ok;
        logic [7:0] d;
        bit         par;
    } ev_t;

    ev_t evq[$];
    bit  both_seen = 1'b0;

    urxd_byte_rx_if rx_if ();

    urxd_byte_rx #(.F_CLK(50_000_000), .BAUD(2_500_000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .URXD  (URXD),
        .o_rx  (rx_if.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_if.ok_rx === 1'b1 || rx_if.err_stop === 1'b1)
            evq.push_back('{t: cyc, ok: rx_if.ok_rx, d: rx_if.dat, par: rx_if.err_par});
        if (rx_if.ok_rx === 1'b1 && rx_if.err_stop === 1'b1)
            both_seen = 1'b1;
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Drives one frame with a bit period of per10/10 clocks; stops after max_t cycles if max_t > 0.
    task automatic send_frame(input logic [7:0] b, input bit stop_v, input bit pflip,
                              input int per10, input int max_t, output int k);
        logic [11:0] fr;
        int len;
        fr = {1'b1, 1'b1, stop_v, (^b) ^ pflip, b, 1'b0};
`ifndef URXD_PARITY_EN
        fr[9] = stop_v;
`endif
        len = (NBITS * per10) / 10;
        if (max_t > 0 && max_t < len) len = max_t;
        k = cyc;
        for (int t = 0; t < len; t++) begin
            URXD = fr[(t * 10) / per10];
            @(posedge clk); #1;
        end
        URXD = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; URXD = 1'b1;
        repeat (3) @(posedge clk); #1;
        checks++;
        if (rx_if.dat !== 8'h00) begin failures++; $display("FAIL reset_dat got=%h exp=00", rx_if.dat); end
        checks++;
        if ({rx_if.ok_rx, rx_if.err_stop, rx_if.err_par, rx_if.en_rx_byte, rx_if.ce_tact} !== 5'b0) begin
            failures++; $display("FAIL reset_strobes got=%b exp=00000",
                {rx_if.ok_rx, rx_if.err_stop, rx_if.err_par, rx_if.en_rx_byte, rx_if.ce_tact});
        end
        checks++;
        if ({rx_if.cb_bit, rx_if.T_start, rx_if.T_dat, rx_if.T_stop} !== 7'b0) begin
            failures++; $display("FAIL reset_debug got=%b exp=0000000",
                {rx_if.cb_bit, rx_if.T_start, rx_if.T_dat, rx_if.T_stop});
        end
        rst_n = 1'b1;
        idle(4);
    endtask

    task automatic test_basic;
        int k;
        evq.delete();
        send_frame(8'h81, 1'b1, 1'b0, NT*10, 0, k);
        idle(NT);
        checks++;
        if (evq.size() != 1) begin
            failures++; $display("FAIL basic_count got=%0d exp=1", evq.size());
        end else begin
            checks++;
            if (evq[0].ok !== 1'b1 || evq[0].d !== 8'h81) begin
                failures++; $display("FAIL basic_ok got ok=%0d dat=%h exp ok=1 dat=81", evq[0].ok, evq[0].d);
            end
            checks++;
            if (evq[0].t !== k + STROBE_OFS) begin
                failures++; $display("FAIL basic_latency got=%0d exp=%0d", evq[0].t - k, STROBE_OFS);
            end
            checks++;
            if (evq[0].par !== 1'b0) begin failures++; $display("FAIL basic_par got=1 exp=0"); end
        end
    endtask

    task automatic test_baud_error;
        int k;
        int pers[2] = '{208, 194};
        foreach (pers[i]) begin
            evq.delete();
            send_frame(8'hA5, 1'b1, 1'b0, pers[i], 0, k);
            idle(NT);
            checks++;
            if (evq.size() != 1 || evq[0].ok !== 1'b1 || evq[0].d !== 8'hA5 || evq[0].par !== 1'b0) begin
                failures++;
                $display("FAIL baud_err_%0d got n=%0d ok=%0d dat=%h exp n=1 ok=1 dat=a5", pers[i], evq.size(),
                    (evq.size() > 0) ? evq[0].ok : 1'b0, (evq.size() > 0) ? evq[0].d : 8'h00);
            end
        end
    endtask

    task automatic test_false_start;
        int k, t_rise, t_fall;
        evq.delete();
        k = cyc; t_rise = -1; t_fall = -1;
        URXD = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (t == 5) URXD = 1'b1;
            @(negedge clk);
            if (rx_if.en_rx_byte === 1'b1 && t_rise < 0) t_rise = cyc;
            if (rx_if.en_rx_byte === 1'b0 && t_rise >= 0 && t_fall < 0) t_fall = cyc;
            @(posedge clk); #1;
        end
        checks++;
        if (t_rise !== k + 3) begin failures++; $display("FAIL glitch_en_rise got=%0d exp=3", t_rise - k); end
        checks++;
        if (t_fall !== k + 2 + NT/2) begin failures++; $display("FAIL glitch_en_fall got=%0d exp=%0d", t_fall - k, 2 + NT/2); end
        checks++;
        if (evq.size() != 0) begin failures++; $display("FAIL glitch_strobes got=%0d exp=0", evq.size()); end
        checks++;
        if (rx_if.dat !== 8'hA5) begin failures++; $display("FAIL glitch_dat got=%h exp=a5", rx_if.dat); end
    endtask

    task automatic test_break;
        int k, k2;
        evq.delete();
        send_frame(8'h3C, 1'b0, 1'b0, NT*10, 0, k);
        URXD = 1'b0;
        idle(50*NT);
        URXD = 1'b1;
        idle(2*NT);
        checks++;
        if (evq.size() != 1 || evq[0].ok !== 1'b0 || evq[0].t !== k + STROBE_OFS) begin
            failures++; $display("FAIL break_err_stop got n=%0d exp n=1 err_stop at +%0d", evq.size(), STROBE_OFS);
        end
        checks++;
        if (rx_if.dat !== 8'hA5) begin failures++; $display("FAIL break_dat got=%h exp=a5", rx_if.dat); end
        evq.delete();
        send_frame(8'h55, 1'b1, 1'b0, NT*10, 0, k2);
        idle(NT);
        checks++;
        if (evq.size() != 1 || evq[0].ok !== 1'b1 || evq[0].d !== 8'h55) begin
            failures++; $display("FAIL break_recover got n=%0d dat=%h exp n=1 dat=55", evq.size(), rx_if.dat);
        end
    endtask

    task automatic test_back_to_back;
        int k1, k2;
        evq.delete();
        send_frame(8'h00, 1'b1, 1'b0, NT*10, 0, k1);
        send_frame(8'hFF, 1'b1, 1'b0, NT*10, 0, k2);
        idle(NT);
        checks++;
        if (evq.size() != 2) begin
            failures++; $display("FAIL b2b_count got=%0d exp=2", evq.size());
        end else begin
            checks++;
            if (evq[0].d !== 8'h00 || evq[1].d !== 8'hFF || !evq[0].ok || !evq[1].ok) begin
                failures++; $display("FAIL b2b_data got=%h,%h exp=00,ff", evq[0].d, evq[1].d);
            end
            checks++;
            if (evq[1].t - evq[0].t !== NBITS*NT) begin
                failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", evq[1].t - evq[0].t, NBITS*NT);
            end
            checks++;
            if (evq[0].t !== k1 + STROBE_OFS) begin
                failures++; $display("FAIL b2b_first_latency got=%0d exp=%0d", evq[0].t - k1, STROBE_OFS);
            end
        end
    endtask

    task automatic test_reset_mid;
        int k;
        evq.delete();
        send_frame(8'h99, 1'b1, 1'b0, NT*10, 5*NT + NT/2, k);
        rst_n = 1'b0;
        #1;
        checks++;
        if (rx_if.dat !== 8'h00 || rx_if.en_rx_byte !== 1'b0 || rx_if.cb_bit !== 4'd0 || rx_if.T_dat !== 1'b0) begin
            failures++; $display("FAIL midrst_outputs got dat=%h en=%b cb=%0d exp dat=00 en=0 cb=0",
                rx_if.dat, rx_if.en_rx_byte, rx_if.cb_bit);
        end
        idle(3);
        rst_n = 1'b1;
        idle(NT*NBITS);
        checks++;
        if (evq.size() != 0) begin failures++; $display("FAIL midrst_strobes got=%0d exp=0", evq.size()); end
        send_frame(8'h42, 1'b1, 1'b0, NT*10, 0, k);
        idle(NT);
        checks++;
        if (evq.size() != 1 || evq[0].d !== 8'h42 || evq[0].ok !== 1'b1 || evq[0].par !== 1'b0) begin
            failures++; $display("FAIL midrst_recover got n=%0d dat=%h exp n=1 dat=42", evq.size(), rx_if.dat);
        end
`ifdef URXD_PARITY_EN
        evq.delete();
        send_frame(8'h42, 1'b1, 1'b1, NT*10, 0, k);
        idle(NT);
        checks++;
        if (evq.size() != 1 || evq[0].ok !== 1'b1 || evq[0].par !== 1'b1 || evq[0].d !== 8'h42) begin
            failures++; $display("FAIL par_wrong got n=%0d exp ok=1 err_par=1 dat=42", evq.size());
        end
`endif
    endtask

    task automatic test_random;
        int k, per10, gap;
        logic [7:0] b, model_dat;
        bit stop_v;
        model_dat = 8'h42;
        for (int i = 0; i < 12; i++) begin
            b      = 8'($urandom);
            stop_v = ($urandom_range(0, 4) != 0);
            per10  = $urandom_range(193, 207);
            gap    = stop_v ? $urandom_range(0, 20) : $urandom_range(3, 20);
            evq.delete();
            send_frame(b, stop_v, 1'b0, per10, 0, k);
            idle(gap);
            if (stop_v) model_dat = b;
            checks++;
            if (evq.size() != 1) begin
                failures++; $display("FAIL rand%0d_count got=%0d exp=1", i, evq.size());
            end else begin
                checks++;
                if (evq[0].ok !== stop_v || evq[0].t !== k + STROBE_OFS) begin
                    failures++; $display("FAIL rand%0d_kind got ok=%0d t=%0d exp ok=%0d t=%0d",
                        i, evq[0].ok, evq[0].t - k, stop_v, STROBE_OFS);
                end
            end
            checks++;
            if (rx_if.dat !== model_dat) begin
                failures++; $display("FAIL rand%0d_dat got=%h exp=%h", i, rx_if.dat, model_dat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_baud_error();
        test_false_start();
        test_break();
        test_back_to_back();
        test_reset_mid();
        test_random();
        checks++;
        if (both_seen !== 1'b0) begin failures++; $display("FAIL ok_and_err_same_cycle got=1 exp=0"); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
